elastic_reg_pipe: RTL and testbench
===================================

// Module: elastic_reg_pipe
// PURPOSE
// - Parametrised successor to the single-bit D flip-flop: a WIDTH-bit, DEPTH-stage register pipeline.
// - Adds a per-stage valid bit, a valid/ready handshake, bubble collapsing, synchronous flush and an occupancy count.
// - Used as a retiming/delay slice between a streaming producer and consumer. Backpressure must stop data without any loss.
// PARAMETERS
// - WIDTH      8   data bits per beat (>=1)
// - DEPTH      4   number of register stages (>=1)
// - RESET_VAL  0   value loaded into every data register on rst (WIDTH bits)
// PORTS
// - clk        in   1                  clock, rising edge
// - rst        in   1                  reset, asynchronous, active-high
// - flush      in   1                  synchronous clear of all valid bits
// - in_valid   in   1                  producer has a beat on in_data
// - in_ready   out  1                  pipe accepts a beat this cycle
// - in_data    in   WIDTH              input beat
// - out_valid  out  1                  last stage holds a valid beat
// - out_ready  in   1                  consumer accepts the beat this cycle
// - out_data   out  WIDTH              last stage data
// - occupancy  out  $clog2(DEPTH+1)    number of valid stages, 0..DEPTH
// BEHAVIOUR
// - Reset (async, any time incl. mid-transfer):
//   - All valid bits 0, all data regs = RESET_VAL, occupancy = 0.
//   - out_valid = 0, out_data = RESET_VAL, in_ready = 1.
// - Stage i state: v[i], d[i]. Stage 0 is the input side; stage DEPTH-1 is the output.
// - Move terms (combinational):
//   - mv[DEPTH-1] = v[DEPTH-1] & out_ready
//   - mv[i] = v[i] & (~v[i+1] | mv[i+1]) for i < DEPTH-1
// - Stage i can load when ~v[i] | mv[i].
//   - in_ready = (~v[0] | mv[0]) & ~flush
//   - Accept = in_valid & in_ready.
// - Per clock, with flush=0:
//   - Stage 0 loads in_data when accepted. Otherwise v[0] <= v[0] & ~mv[0].
//   - Stage i>0 loads d[i-1] when mv[i-1]. Otherwise v[i] <= v[i] & ~mv[i].
//   - Data regs update only on a load. They hold their value otherwise (no toggling on bubbles).
// - Bubble collapsing: a beat advances into any empty downstream stage even while out_ready=0.
//   - A stalled pipe fills to DEPTH beats before in_ready drops.
// - Latency: a beat accepted at edge N shows out_valid at edge N+DEPTH when unstalled and the pipe is empty.
// - Throughput: 1 beat/cycle sustained while out_ready=1.
// - Simultaneous accept and output: both happen, occupancy unchanged.
//   - A full pipe with out_ready=1 keeps in_ready=1 (ready chains combinationally from out_ready).
// - occupancy = popcount(v). It is registered: the next value = current + accept - (out_valid & out_ready).
//   - The register must equal popcount(v) at every edge. The bench checks this.
// - flush=1:
//   - At the next edge all v <= 0 and occupancy <= 0. Data regs hold.
//   - in_ready=0 that cycle, so no beat is accepted.
//   - out_valid is unaffected combinationally that cycle. A transfer with out_ready=1 in the flush cycle counts as consumed.
// - out_data is meaningful only when out_valid=1. Consumers must not rely on it otherwise.
// - No combinational path from in_valid/in_data to outputs.
//   - The path out_ready -> in_ready is combinational by design. It is documented for integrators.
// STRUCTURE
// - Sub-module pipe_stage:
//   - Ports: clk, rst, flush, load, drain, d_in, v_q, d_q.
//   - One valid+data register with async reset to {0, RESET_VAL}.
//   - Instantiate DEPTH of them in a generate loop. The move/ready chain lives in the top level.
// - No new shared-package entries. The occupancy width is a local constant CNT_W = $clog2(DEPTH+1).
// TESTING
// - Reset: assert rst mid-stream with 3 beats held.
//   - Required: v=0, out_valid=0, out_data=RESET_VAL, occupancy=0, in_ready=1 immediately, before any clock edge.
// - Latency/throughput (DEPTH=4): stream 0x01..0x10 with out_ready=1.
//   - Required: 0x01 appears 4 cycles after acceptance, then one beat per cycle, in order, with no gaps.
// - Backpressure (DEPTH=4): out_ready=0, push 0xA1..0xA5.
//   - Required: 0xA1..0xA4 accepted, occupancy=4, in_ready=0, 0xA5 held.
//   - Raise out_ready: 0xA1..0xA5 delivered in order.
// - Bubble collapse: push 0x11, 2 idle cycles, push 0x22, out_ready=0.
//   - Required: both beats pack to stages 3 and 2, occupancy=2, in_ready=1.
// - Full pass-through: full pipe, out_ready=1, in_valid=1 on the same cycle.
//   - Required: in_ready=1, one beat in and one out, occupancy stays 4.
// - Flush: occupancy=3, assert flush 1 cycle with in_valid=1.
//   - Required: in_ready=0 that cycle, next cycle occupancy=0, out_valid=0.
//   - Then the next beat goes through with latency DEPTH.
// - Repeat all scenarios for DEPTH=1 and WIDTH=1. A scoreboard checks order, no loss and no duplication.

Source files
------------

// File: rtl/elastic_reg_pipe_pkg.sv
// elastic_reg_pipe_pkg: shared defaults for the elastic register pipeline slice.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package elastic_reg_pipe_pkg;

  // Default geometry used when an instance does not override it.
  localparam int unsigned ERP_DEF_WIDTH = 8;
  localparam int unsigned ERP_DEF_DEPTH = 4;

endpackage : elastic_reg_pipe_pkg

// File: rtl/elastic_reg_pipe_stage.sv
// pipe_stage: one valid+data register of the elastic pipeline.
// Latency: 1 cycle from load to v_q/d_q.
// Backpressure: none locally; load/drain are decided by the parent's move chain.
// Ports:
//   clk, rst     clock (rising edge) and async active-high reset
//   flush        clears the valid bit at the next edge, data holds
//   load         capture d_in and mark the stage valid
//   drain        the held beat leaves this cycle and nothing replaces it
//   d_in         incoming beat
//   v_q, d_q     registered valid bit and data
module pipe_stage
  import elastic_reg_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = ERP_DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] d_in,
  output logic             v_q,
  output logic [WIDTH-1:0] d_q
);

  logic             v_d;
  logic [WIDTH-1:0] d_d;

  // Flush wins over everything and leaves the data register untouched, so a
  // flush never toggles data flops. Load wins over drain because a stage that
  // is both emptied and refilled in the same cycle ends up valid.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (flush) begin
      v_d = 1'b0;
    end else if (load) begin
      v_d = 1'b1;
      d_d = d_in;
    end else if (drain) begin
      v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= 1'b0;
      d_q <= RESET_VAL;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

endmodule : pipe_stage

// File: rtl/elastic_reg_pipe.sv
// elastic_reg_pipe: WIDTH-bit, DEPTH-stage register pipeline with valid/ready, bubble collapse, flush and occupancy.
// Latency: DEPTH cycles from accept to out_valid on an empty unstalled pipe; 1 beat/cycle sustained.
// Backpressure: beats are never dropped; in_ready falls only when all DEPTH stages are full and out_ready=0.
// Ports:
//   clk, rst               clock (rising edge) and async active-high reset
//   flush                  synchronous clear of every valid bit (data holds), blocks input that cycle
//   in_valid/in_ready      producer handshake, in_data is the beat
//   out_valid/out_ready    consumer handshake, out_data is the last stage
//   occupancy              registered count of valid stages, 0..DEPTH
// Timing note for integrators: out_ready -> in_ready is a combinational path
// through the move chain; in_valid/in_data reach no output combinationally.
module elastic_reg_pipe
  import elastic_reg_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = ERP_DEF_WIDTH,
  parameter int unsigned      DEPTH     = ERP_DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] stg_v;     // per-stage valid
  logic [WIDTH-1:0] stg_d [DEPTH];
  logic [DEPTH-1:0] mv;        // stage i hands its beat downstream this cycle
  logic [DEPTH-1:0] stg_load;
  logic [DEPTH-1:0] stg_drain;
  logic             stall_c;   // running "everything below here is blocked"
  logic             accept;
  logic             out_xfer;

  logic [CNT_W-1:0] occ_q;
  logic [CNT_W-1:0] occ_d;

  // Move chain, walked from the output stage back toward the input.
  // A valid stage can move unless every stage below it is valid and the
  // consumer is stalled. Tracking that as a single running term is the same
  // function as mv[i] = v[i] & (~v[i+1] | mv[i+1]) but avoids a vector that
  // feeds back on itself.
  always_comb begin
    mv      = '0;
    stall_c = ~out_ready;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      mv[i]   = stg_v[i] & ~stall_c;
      stall_c = stall_c & stg_v[i];
    end
  end

  assign in_ready  = (~stg_v[0] | mv[0]) & ~flush;
  assign accept    = in_valid & in_ready;
  assign out_valid = stg_v[DEPTH-1];
  assign out_data  = stg_d[DEPTH-1];
  assign out_xfer  = out_valid & out_ready;

  // Stage 0 loads from the input port; every other stage loads from its
  // upstream neighbour whenever that neighbour moves.
  always_comb begin
    stg_load  = '0;
    stg_drain = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      stg_drain[i] = mv[i];
      if (i == 0) begin
        stg_load[i] = accept;
      end else begin
        stg_load[i] = mv[i-1];
      end
    end
  end

  for (genvar gi = 0; gi < int'(DEPTH); gi++) begin : g_stage
    logic [WIDTH-1:0] stage_in;

    if (gi == 0) begin : g_head
      assign stage_in = in_data;
    end else begin : g_body
      assign stage_in = stg_d[gi-1];
    end

    pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .load  (stg_load[gi]),
      .drain (stg_drain[gi]),
      .d_in  (stage_in),
      .v_q   (stg_v[gi]),
      .d_q   (stg_d[gi])
    );
  end

  // Occupancy is kept as a counter rather than a popcount of the valid bits
  // so the output is a clean flop. Accept is already blocked during flush,
  // so flush alone decides the clear.
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else begin
      occ_d = occ_q + CNT_W'(accept) - CNT_W'(out_xfer);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule : elastic_reg_pipe

// File: tb/tb_elastic_reg_pipe.sv
// tb_elastic_reg_pipe: bench for four elastic_reg_pipe geometries (W8/D4, W8/D1, W1/D4, W1/D1).
// Latency: n/a.
// Backpressure: the bench drives out_ready per scenario.
module tb_elastic_reg_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0;
  logic       flush     [4];
  logic       in_valid  [4];
  logic       out_ready [4];
  logic       in_ready  [4];
  logic       out_valid [4];
  logic [7:0] in_data   [4];
  logic [7:0] od        [4];
  logic [3:0] oc        [4];

  logic [7:0] o0_d, o1_d;
  logic       o2_d, o3_d;
  logic [2:0] c0, c2;
  logic       c1, c3;

  elastic_reg_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h5A)) dut0 (
    .clk(clk), .rst(rst), .flush(flush[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(o0_d), .occupancy(c0));
  elastic_reg_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'hC3)) dut1 (
    .clk(clk), .rst(rst), .flush(flush[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(o1_d), .occupancy(c1));
  elastic_reg_pipe #(.WIDTH(1), .DEPTH(4), .RESET_VAL(1'b1)) dut2 (
    .clk(clk), .rst(rst), .flush(flush[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2][0]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_data(o2_d), .occupancy(c2));
  elastic_reg_pipe #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b0)) dut3 (
    .clk(clk), .rst(rst), .flush(flush[3]), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .in_data(in_data[3][0]), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
    .out_data(o3_d), .occupancy(c3));

  assign od[0] = o0_d;
  assign od[1] = o1_d;
  assign od[2] = {7'b0, o2_d};
  assign od[3] = {7'b0, o3_d};
  assign oc[0] = 4'(c0);
  assign oc[1] = 4'(c1);
  assign oc[2] = 4'(c2);
  assign oc[3] = 4'(c3);

  function automatic int dep(input int k);
    return (k == 1 || k == 3) ? 1 : 4;
  endfunction

  function automatic logic [7:0] msk(input int k);
    return (k >= 2) ? 8'h01 : 8'hFF;
  endfunction

  function automatic logic [7:0] rv(input int k);
    case (k)
      0:       return 8'h5A;
      1:       return 8'hC3;
      2:       return 8'h01;
      default: return 8'h00;
    endcase
  endfunction

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cur     = 0;
  int         m_occ   = 0;
  int         m_nxt;
  logic [7:0] m_exp;
  logic [7:0] sb [$];

  // Scoreboard: push masked beats on accept, pop and compare on delivery,
  // and track the expected occupancy independently of the DUT.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      m_occ = 0;
    end else begin
      n_tests++;
      if (oc[cur] !== 4'(m_occ)) begin
        n_fail++;
        $display("FAIL sb_occupancy k=%0d got=%0d exp=%0d t=%0t", cur, oc[cur], m_occ, $time);
      end
      m_nxt = m_occ;
      if (out_valid[cur] === 1'b1 && out_ready[cur] === 1'b1) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_extra_beat k=%0d got=%0h exp=none t=%0t", cur, od[cur], $time);
        end else begin
          m_exp = sb.pop_front();
          if (od[cur] !== m_exp) begin
            n_fail++;
            $display("FAIL sb_data k=%0d got=%0h exp=%0h t=%0t", cur, od[cur], m_exp, $time);
          end
        end
        m_nxt--;
      end
      if (in_valid[cur] === 1'b1 && in_ready[cur] === 1'b1) begin
        sb.push_back(in_data[cur] & msk(cur));
        m_nxt++;
      end
      if (flush[cur] === 1'b1) begin
        sb.delete();
        m_nxt = 0;
      end
      m_occ = m_nxt;
    end
  end

  task automatic drain(input int k, output bit ok);
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b1;
    for (int c = 0; c < 40 && sb.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    ok = (sb.size() == 0);
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
  endtask

  task automatic test_power_on();
    #1 rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1 || oc[k] !== 4'd0 || od[k] !== rv(k)) begin
        n_fail++;
        $display("FAIL por_state k=%0d got v=%b r=%b occ=%0d d=%0h exp v=0 r=1 occ=0 d=%0h",
                 k, out_valid[k], in_ready[k], oc[k], od[k], rv(k));
      end
    end
    @(negedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset(input int k);
    int d = dep(k);
    int held = (d < 3) ? d : 3;
    cur = k;
    out_ready[k] = 1'b0;
    in_valid[k]  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data[k] = 8'h31 + 8'(i);
      @(posedge clk); #1;
    end
    in_valid[k] = 1'b0;
    @(negedge clk);
    n_tests++;
    if (oc[k] !== 4'(held)) begin
      n_fail++;
      $display("FAIL rst_pre_occ k=%0d got=%0d exp=%0d", k, oc[k], held);
    end
    #3 rst = 1'b1;
    #1;
    n_tests++;
    if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1 || oc[k] !== 4'd0 || od[k] !== rv(k)) begin
      n_fail++;
      $display("FAIL rst_async k=%0d got v=%b r=%b occ=%0d d=%0h exp v=0 r=1 occ=0 d=%0h",
               k, out_valid[k], in_ready[k], oc[k], od[k], rv(k));
    end
    @(negedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_latency(input int k);
    int d = dep(k);
    logic exp_v;
    bit ok;
    cur = k;
    out_ready[k] = 1'b1;
    for (int c = 0; c < 16 + d + 1; c++) begin
      in_valid[k] = (c < 16);
      in_data[k]  = 8'(c + 1);
      @(negedge clk);
      if (c < 16) begin
        n_tests++;
        if (in_ready[k] !== 1'b1) begin
          n_fail++;
          $display("FAIL lat_in_ready k=%0d c=%0d got=%b exp=1", k, c, in_ready[k]);
        end
      end
      exp_v = (c >= d && c < 16 + d);
      n_tests++;
      if (out_valid[k] !== exp_v) begin
        n_fail++;
        $display("FAIL lat_out_valid k=%0d c=%0d got=%b exp=%b", k, c, out_valid[k], exp_v);
      end
      if (exp_v && od[k] !== (8'(c - d + 1) & msk(k))) begin
        n_fail++;
        $display("FAIL lat_data k=%0d c=%0d got=%0h exp=%0h", k, c, od[k], 8'(c - d + 1) & msk(k));
      end
      @(posedge clk); #1;
    end
    in_valid[k] = 1'b0;
    drain(k, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL lat_drain k=%0d got=%0d left exp=0", k, sb.size());
    end
  endtask

  task automatic test_backpressure(input int k);
    int d = dep(k);
    int acc = 0;
    bit ok;
    cur = k;
    out_ready[k] = 1'b0;
    in_valid[k]  = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_data[k] = 8'hA1 + 8'(acc);
      @(negedge clk);
      n_tests++;
      if (in_ready[k] !== 1'(c < d)) begin
        n_fail++;
        $display("FAIL bp_in_ready k=%0d c=%0d got=%b exp=%b", k, c, in_ready[k], 1'(c < d));
      end
      if (in_ready[k] === 1'b1) acc++;
      @(posedge clk); #1;
    end
    in_data[k] = 8'hA1 + 8'(acc);
    @(negedge clk);
    n_tests++;
    if (oc[k] !== 4'(d) || out_valid[k] !== 1'b1 || od[k] !== (8'hA1 & msk(k))) begin
      n_fail++;
      $display("FAIL bp_full k=%0d got occ=%0d v=%b d=%0h exp occ=%0d v=1 d=%0h",
               k, oc[k], out_valid[k], od[k], d, 8'hA1 & msk(k));
    end
    @(posedge clk); #1;
    out_ready[k] = 1'b1;
    for (int c = 0; c < 20 && acc < 5; c++) begin
      in_data[k] = 8'hA1 + 8'(acc);
      @(negedge clk);
      if (in_ready[k] === 1'b1) acc++;
      @(posedge clk); #1;
    end
    in_valid[k] = 1'b0;
    n_tests++;
    if (acc != 5) begin
      n_fail++;
      $display("FAIL bp_accepted k=%0d got=%0d exp=5", k, acc);
    end
    drain(k, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL bp_drain k=%0d got=%0d left exp=0", k, sb.size());
    end
  endtask

  task automatic test_bubble(input int k);
    int d = dep(k);
    bit ok;
    cur = k;
    out_ready[k] = 1'b0;
    in_valid[k]  = 1'b1;
    in_data[k]   = 8'h11;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid[k] = 1'b1;
    in_data[k]  = 8'h22;
    @(negedge clk);
    n_tests++;
    if (in_ready[k] !== 1'(d > 1)) begin
      n_fail++;
      $display("FAIL bub_rdy_second k=%0d got=%b exp=%b", k, in_ready[k], 1'(d > 1));
    end
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    repeat (d) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_tests++;
    if (oc[k] !== 4'((d > 1) ? 2 : 1) || in_ready[k] !== 1'(d > 2) ||
        out_valid[k] !== 1'b1 || od[k] !== (8'h11 & msk(k))) begin
      n_fail++;
      $display("FAIL bub_packed k=%0d got occ=%0d r=%b v=%b d=%0h exp occ=%0d r=%b v=1 d=%0h",
               k, oc[k], in_ready[k], out_valid[k], od[k], (d > 1) ? 2 : 1, 1'(d > 2), 8'h11 & msk(k));
    end
    @(posedge clk); #1;
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
    @(negedge clk);
    n_tests++;
    if (d > 1) begin
      if (out_valid[k] !== 1'b1 || od[k] !== (8'h22 & msk(k))) begin
        n_fail++;
        $display("FAIL bub_next k=%0d got v=%b d=%0h exp v=1 d=%0h", k, out_valid[k], od[k], 8'h22 & msk(k));
      end
    end else if (out_valid[k] !== 1'b0) begin
      n_fail++;
      $display("FAIL bub_next k=%0d got v=%b exp v=0", k, out_valid[k]);
    end
    @(posedge clk); #1;
    drain(k, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL bub_drain k=%0d got=%0d left exp=0", k, sb.size());
    end
  endtask

  task automatic test_full_pass(input int k);
    int d = dep(k);
    int acc = 0;
    bit ok;
    cur = k;
    out_ready[k] = 1'b0;
    in_valid[k]  = 1'b1;
    for (int c = 0; c < d + 2 && acc < d; c++) begin
      in_data[k] = 8'h30 + 8'(acc);
      @(negedge clk);
      if (in_ready[k] === 1'b1) acc++;
      @(posedge clk); #1;
    end
    in_valid[k] = 1'b0;
    @(negedge clk);
    n_tests++;
    if (oc[k] !== 4'(d) || in_ready[k] !== 1'b0) begin
      n_fail++;
      $display("FAIL fp_full k=%0d got occ=%0d r=%b exp occ=%0d r=0", k, oc[k], in_ready[k], d);
    end
    @(posedge clk); #1;
    in_valid[k]  = 1'b1;
    in_data[k]   = 8'h40;
    out_ready[k] = 1'b1;
    @(negedge clk);
    n_tests++;
    if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b1 || oc[k] !== 4'(d) || od[k] !== (8'h30 & msk(k))) begin
      n_fail++;
      $display("FAIL fp_pass k=%0d got r=%b v=%b occ=%0d d=%0h exp r=1 v=1 occ=%0d d=%0h",
               k, in_ready[k], out_valid[k], oc[k], od[k], d, 8'h30 & msk(k));
    end
    @(posedge clk); #1;
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b0;
    @(negedge clk);
    n_tests++;
    if (oc[k] !== 4'(d) || out_valid[k] !== 1'b1 || od[k] !== (((d > 1) ? 8'h31 : 8'h40) & msk(k))) begin
      n_fail++;
      $display("FAIL fp_after k=%0d got occ=%0d v=%b d=%0h exp occ=%0d v=1 d=%0h",
               k, oc[k], out_valid[k], od[k], d, ((d > 1) ? 8'h31 : 8'h40) & msk(k));
    end
    @(posedge clk); #1;
    drain(k, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL fp_drain k=%0d got=%0d left exp=0", k, sb.size());
    end
  endtask

  task automatic test_flush(input int k);
    int d = dep(k);
    int want = (d < 3) ? d : 3;
    int acc = 0;
    bit ok;
    cur = k;
    out_ready[k] = 1'b0;
    in_valid[k]  = 1'b1;
    for (int c = 0; c < 6 && acc < want; c++) begin
      in_data[k] = 8'h50 + 8'(acc);
      @(negedge clk);
      if (in_ready[k] === 1'b1) acc++;
      @(posedge clk); #1;
    end
    in_valid[k] = 1'b0;
    repeat (d) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_tests++;
    if (oc[k] !== 4'(want)) begin
      n_fail++;
      $display("FAIL fl_pre_occ k=%0d got=%0d exp=%0d", k, oc[k], want);
    end
    @(posedge clk); #1;
    flush[k]     = 1'b1;
    in_valid[k]  = 1'b1;
    in_data[k]   = 8'h66;
    out_ready[k] = 1'b1;
    @(negedge clk);
    n_tests++;
    if (in_ready[k] !== 1'b0 || out_valid[k] !== 1'b1) begin
      n_fail++;
      $display("FAIL fl_cycle k=%0d got r=%b v=%b exp r=0 v=1", k, in_ready[k], out_valid[k]);
    end
    @(posedge clk); #1;
    flush[k]     = 1'b0;
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b0;
    @(negedge clk);
    n_tests++;
    if (oc[k] !== 4'd0 || out_valid[k] !== 1'b0) begin
      n_fail++;
      $display("FAIL fl_after k=%0d got occ=%0d v=%b exp occ=0 v=0", k, oc[k], out_valid[k]);
    end
    @(posedge clk); #1;
    in_valid[k]  = 1'b1;
    in_data[k]   = 8'h77;
    out_ready[k] = 1'b1;
    @(negedge clk);
    n_tests++;
    if (in_ready[k] !== 1'b1) begin
      n_fail++;
      $display("FAIL fl_accept k=%0d got=%b exp=1", k, in_ready[k]);
    end
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    for (int c = 1; c <= d; c++) begin
      @(negedge clk);
      n_tests++;
      if (out_valid[k] !== 1'(c == d)) begin
        n_fail++;
        $display("FAIL fl_latency k=%0d c=%0d got=%b exp=%b", k, c, out_valid[k], 1'(c == d));
      end
      if (c == d && od[k] !== (8'h77 & msk(k))) begin
        n_fail++;
        $display("FAIL fl_data k=%0d got=%0h exp=%0h", k, od[k], 8'h77 & msk(k));
      end
      @(posedge clk); #1;
    end
    drain(k, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL fl_drain k=%0d got=%0d left exp=0", k, sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 4; k++) begin
      flush[k]     = 1'b0;
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b0;
      in_data[k]   = 8'h00;
    end
    test_power_on();
    for (int k = 0; k < 4; k++) begin
      test_reset(k);
      test_latency(k);
      test_backpressure(k);
      test_bubble(k);
      test_full_pass(k);
      test_flush(k);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_elastic_reg_pipe
